// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS-lite datapath: sequences each opcode and drives mux selects, enables and aluop.
// Moore outputs decoded from the state register; FETCH write enables follow mem_ready; everything reads 0 while rst_n is low.
module mips_multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_src,
  output logic [1:0]             aluop,
  output logic                   illegal_op,
  output logic [STATE_WIDTH-1:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ORIEX  = 4'd9,
    ORIWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_R   = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ORI = OP_WIDTH'(6'b001101);
  localparam logic [OP_WIDTH-1:0] OP_J   = OP_WIDTH'(6'b000010);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_ORI = 2'b11;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ORI:       state <= ORIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (mem_ready) state <= FETCH;
        EXEC:   state <= ALUWB;
        ALUWB:  state <= FETCH;
        BRANCH: state <= FETCH;
        ORIEX:  state <= ORIWB;
        ORIWB:  state <= FETCH;
        JUMP:   state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  logic known_op;
  assign known_op = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ORI) || (op == OP_J);

  // The rst_n gate keeps the async-reset FETCH state from issuing a fetch while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    aluop         = ALU_ADD;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !known_op;
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          aluop     = ALU_R;
        end
        ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          aluop         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        ORIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = ALU_ORI;
        end
        ORIWB: reg_write = 1'b1;
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = rst_n ? STATE_WIDTH'(state) : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control: per-cycle state, control word and illegal_op checks.
module tb_mips_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, aluop;
  logic [3:0] dbg_state;

  int errors = 0;
  int checks = 0;

  mips_multicycle_control #(.OP_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .aluop(aluop), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a | alu_src_b | pc_src | aluop
  logic [15:0] ctl;
  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, aluop};

  localparam logic [15:0] C_ZERO   = 16'h0000;
  localparam logic [15:0] C_FETCH1 = {10'b1001010000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] C_FETCH0 = {10'b0001000000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] C_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [15:0] C_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] C_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_EXEC   = {10'b0000000001, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] C_ALUWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_BRANCH = {10'b0100000001, 2'b00, 2'b01, 2'b01};
  localparam logic [15:0] C_ORIEX  = {10'b0000000001, 2'b10, 2'b00, 2'b11};
  localparam logic [15:0] C_ORIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] C_JUMP   = {10'b1000000000, 2'b00, 2'b10, 2'b00};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive inputs just after a falling edge, check mid-low-phase, then advance one cycle.
  task automatic cyc(input string tag, input logic [5:0] o, input logic mr,
                     input logic [3:0] st, input logic [15:0] c, input logic ill);
    op = o;
    mem_ready = mr;
    #1;
    check({tag, ".state"}, {12'b0, dbg_state}, {12'b0, st});
    check({tag, ".ctl"}, ctl, c);
    check({tag, ".ill"}, {15'b0, illegal_op}, {15'b0, ill});
    check({tag, ".excl"}, {14'b0, 2'(reg_write + mem_write + pc_write)} <= 16'd1 ? 16'd1 : 16'd0, 16'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    op = OP_LW;
    mem_ready = 1'b1;
    #3;
    check("reset.ctl", ctl, C_ZERO);
    check("reset.state", {12'b0, dbg_state}, 16'd0);
    check("reset.ill", {15'b0, illegal_op}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw, with op disturbed after MEMADR to show it is ignored
    cyc("lw.fetch",  OP_LW, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("lw.decode", OP_LW, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("lw.memadr", OP_LW, 1'b1, 4'd2, C_MEMADR, 1'b0);
    cyc("lw.memrd",  OP_R,  1'b1, 4'd3, C_MEMRD,  1'b0);
    cyc("lw.memwb",  OP_R,  1'b1, 4'd4, C_MEMWB,  1'b0);

    cyc("r.fetch",  OP_R, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("r.decode", OP_R, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("r.exec",   OP_R, 1'b1, 4'd6, C_EXEC,   1'b0);
    cyc("r.aluwb",  OP_R, 1'b1, 4'd7, C_ALUWB,  1'b0);

    cyc("beq.fetch",  OP_BEQ, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("beq.decode", OP_BEQ, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("beq.branch", OP_BEQ, 1'b1, 4'd8, C_BRANCH, 1'b0);

    cyc("ori.fetch",  OP_ORI, 1'b1, 4'd0,  C_FETCH1, 1'b0);
    cyc("ori.decode", OP_ORI, 1'b1, 4'd1,  C_DEC,    1'b0);
    cyc("ori.ex",     OP_ORI, 1'b1, 4'd9,  C_ORIEX,  1'b0);
    cyc("ori.wb",     OP_ORI, 1'b1, 4'd10, C_ORIWB,  1'b0);

    cyc("j.fetch",  OP_J, 1'b1, 4'd0,  C_FETCH1, 1'b0);
    cyc("j.decode", OP_J, 1'b1, 4'd1,  C_DEC,    1'b0);
    cyc("j.jump",   OP_J, 1'b1, 4'd11, C_JUMP,   1'b0);

    // sw with 3 fetch stalls and 2 write stalls: 9 cycles total
    cyc("sw.fetch_w0", OP_SW, 1'b0, 4'd0, C_FETCH0, 1'b0);
    cyc("sw.fetch_w1", OP_SW, 1'b0, 4'd0, C_FETCH0, 1'b0);
    cyc("sw.fetch_w2", OP_SW, 1'b0, 4'd0, C_FETCH0, 1'b0);
    cyc("sw.fetch",    OP_SW, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("sw.decode",   OP_SW, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("sw.memadr",   OP_SW, 1'b1, 4'd2, C_MEMADR, 1'b0);
    cyc("sw.memwr_w0", OP_SW, 1'b0, 4'd5, C_MEMWR,  1'b0);
    cyc("sw.memwr_w1", OP_SW, 1'b0, 4'd5, C_MEMWR,  1'b0);
    cyc("sw.memwr",    OP_SW, 1'b1, 4'd5, C_MEMWR,  1'b0);

    // undefined opcode
    cyc("bad.fetch",  OP_BAD, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("bad.decode", OP_BAD, 1'b1, 4'd1, C_DEC,    1'b1);

    // lw aborted by reset while MEMRD is stalled
    cyc("rst.fetch",  OP_LW, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("rst.decode", OP_LW, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("rst.memadr", OP_LW, 1'b1, 4'd2, C_MEMADR, 1'b0);
    cyc("rst.memrd",  OP_LW, 1'b0, 4'd3, C_MEMRD,  1'b0);
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst.async.ctl", ctl, C_ZERO);
    check("rst.async.state", {12'b0, dbg_state}, 16'd0);
    @(posedge clk);
    #1;
    check("rst.held.ctl", ctl, C_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post.fetch",  OP_R, 1'b1, 4'd0, C_FETCH1, 1'b0);
    cyc("post.decode", OP_R, 1'b1, 4'd1, C_DEC,    1'b0);
    cyc("post.exec",   OP_R, 1'b1, 4'd6, C_EXEC,   1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-lite datapath.
- Sits directly upstream of the ALU control decoder. It sequences fetch/decode/execute/memory/writeback per opcode and drives the 2-bit `aluop` that the ALU control decoder refines using `func`.
- Also drives all datapath mux selects and register/memory enables.
- Waits on a memory-ready handshake for instruction fetch, load and store.

Parameters:
OP_WIDTH, 6, opcode field width
STATE_WIDTH, 4, state register width (exported on dbg_state)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  6  instruction opcode, from the IR, valid from DECODE onward
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (branch)
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  register write data select: 1=MDR, 0=ALUOut
reg_dst  output  1  destination register select: 1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0=PC, 1=regA
alu_src_b  output  2  ALU B select: 00=regB, 01=const 4, 10=immediate, 11=sext imm<<2
pc_src  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
aluop  output  2  to ALU control: 00=ADD, 01=SUB, 10=R_TYPE, 11=ORI (shared header macros)
illegal_op  output  1  undefined opcode seen in DECODE
dbg_state  output  4  current state

Behaviour:
- Recognised opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - ori 001101
  - j 000010
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ORIEX=9, ORIWB=10, JUMP=11.
- Encodings 12–15 are unreachable. If entered, the next state is FETCH and all outputs are 0.
- Reset:
  - rst_n low drives state to FETCH asynchronously.
  - While rst_n=0, every output is forced to 0 combinationally, including mem_read; dbg_state reads 0.
  - Reset asserted mid-instruction aborts the instruction with no further writes.
- Outputs are Moore, decoded from state. The only exceptions are ir_write/pc_write in FETCH (gated by mem_ready) and illegal_op (decoded from op in DECODE).
- Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=ADD, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, aluop=ADD (branch target precompute).
  - Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, ori→ORIEX, j→JUMP.
  - Any other op: illegal_op=1 for this cycle, next state FETCH, no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, aluop=ADD. Next state MEMRD if op=lw, else MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, aluop=R_TYPE. Next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=SUB, pc_write_cond=1, pc_src=01. Next state FETCH.
- ORIEX: alu_src_a=1, alu_src_b=10, aluop=ORI. Next state ORIWB.
- ORIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10. Next state FETCH.
- Latency with mem_ready held at 1, in cycles: lw 5, sw 4, R 4, ori 4, beq 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- op changes outside DECODE/MEMADR have no effect.
- reg_write, mem_write and pc_write are never asserted in the same cycle.

Test Plan:
- Reset then mem_ready=1, op=100011 (lw): dbg_state 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5. aluop=00 throughout.
- op=000000 (R-type), mem_ready=1: dbg_state 0,1,6,7,0. aluop=10 in EXEC. reg_dst=1 and reg_write=1 in ALUWB.
- op=000100 (beq), then op=001101 (ori): BRANCH asserts aluop=01, pc_write_cond=1, pc_src=01. ORIEX asserts aluop=11, ORIWB asserts reg_write=1 with reg_dst=0.
- op=101011 (sw), mem_ready low for 3 cycles in FETCH and 2 cycles in MEMWR: FETCH holds with mem_read=1 and ir_write=0 until mem_ready. MEMWR holds mem_write=1. Total 9 cycles.
- op=111111 (undefined): illegal_op=1 for exactly the DECODE cycle, then FETCH. No reg_write/mem_write/pc_write in that instruction beyond the fetch PC update.
- Assert rst_n=0 asynchronously mid-MEMRD: all outputs 0 immediately. After release, dbg_state=0 and the FETCH outputs resume.
